// File: rtl/tick_ctrl_pkg.sv
// Shared types and constants for the tick/clock-enable scheduler.
// Channel state encoding, default sizing and the effective-divide helper.
package tick_ctrl_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_DIV   = 100;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    ARMING    = 2'd1,
    ON        = 2'd2,
    DISARMING = 2'd3
  } ch_state_t;

  // A ratio of 0 behaves like 1: a tick every cycle.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/tick_ch_fsm.sv
// One requester's enable FSM: grants and revokes only on wrap edges so the
// channel always sees whole tick periods.
module tick_ch_fsm
  import tick_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_req,
  input  logic wrap,
  output logic en_ack,
  output logic ch_tick,
  output logic active_nxt
);

  ch_state_t state_q, state_d;
  logic      ack_q, ack_d;
  logic      ch_tick_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:       if (en_req) state_d = ARMING;
      ARMING:    if (!en_req) state_d = OFF;
                 else if (wrap) state_d = ON;
      ON:        if (!en_req) state_d = DISARMING;
      DISARMING: if (en_req) state_d = ON;
                 else if (wrap) state_d = OFF;
      default:   state_d = OFF;
    endcase
    ack_d      = (state_d == ON) || (state_d == DISARMING);
    active_nxt = (state_d != OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      ack_q     <= 1'b0;
      ch_tick_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      // Tick only if the channel still holds the grant after this wrap.
      ch_tick_q <= wrap & ack_d;
    end
  end

  assign en_ack  = ack_q;
  assign ch_tick = ch_tick_q;

endmodule

// File: rtl/tick_enable_ctrl.sv
// Programmable periodic tick generator with per-channel tick-aligned enables.
// Divide ratio changes are double-buffered and take effect on a wrap.
module tick_enable_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] en_req,
  output logic [NUM_CH-1:0] en_ack,
  output logic              tick,
  output logic [NUM_CH-1:0] ch_tick,
  output logic              busy
);

  logic [DIV_W-1:0]  count_q, count_d;
  logic [DIV_W-1:0]  div_cur_q, div_cur_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [DIV_W-1:0]  d_eff;
  logic              pend_valid_q, pend_valid_d;
  logic              tick_q, cfg_ready_q, busy_q;
  logic              wrap;
  logic [NUM_CH-1:0] active_nxt;

  assign d_eff = DIV_W'(eff_div(32'(div_cur_q)));
  assign wrap  = (count_q == d_eff - DIV_W'(1));

  always_comb begin
    count_d      = wrap ? '0 : count_q + DIV_W'(1);
    div_cur_d    = div_cur_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    // Load and accept are exclusive: load needs a pending value, accept needs none.
    if (wrap && pend_valid_q) begin
      div_cur_d    = pend_div_q;
      pend_valid_d = 1'b0;
    end else if (cfg_valid && !pend_valid_q) begin
      pend_div_d   = cfg_div;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      div_cur_q    <= DIV_W'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_cur_q    <= div_cur_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= wrap;
      cfg_ready_q  <= !pend_valid_d;
      busy_q       <= (|active_nxt) | pend_valid_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tick_ch_fsm u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_req     (en_req[gi]),
      .wrap       (wrap),
      .en_ack     (en_ack[gi]),
      .ch_tick    (ch_tick[gi]),
      .active_nxt (active_nxt[gi])
    );
  end

  assign tick      = tick_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tick_enable_ctrl.sv
// Directed bench for tick_enable_ctrl: period, config handshake, channel
// grant/revoke timing and asynchronous reset, with hand-derived expectations.
module tb_tick_enable_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div = 16'd0;
  logic [3:0]  en_req = 4'd0;
  logic [3:0]  en_ack;
  logic        tick;
  logic [3:0]  ch_tick;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;   // rising edges since last reset release

  tick_enable_ctrl #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .en_req    (en_req),
    .en_ack    (en_ack),
    .tick      (tick),
    .ch_tick   (ch_tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({tick, ch_tick, en_ack, cfg_ready, busy} !== 11'b0_0000_0000_1_0) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=%b", {tick, ch_tick, en_ack, cfg_ready, busy}, 11'b0_0000_0000_1_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic test_default_period();
    for (int e = 1; e <= 300; e++) begin
      step();
      n_tests++;
      if (tick !== (ecnt % 100 == 0)) begin
        n_fail++;
        $display("FAIL default_tick edge=%0d got=%b exp=%b", ecnt, tick, (ecnt % 100 == 0));
      end
      n_tests++;
      if ({ch_tick, en_ack, busy} !== 9'd0) begin
        n_fail++;
        $display("FAIL default_idle edge=%0d got=%b exp=0", ecnt, {ch_tick, en_ack, busy});
      end
    end
  endtask

  // Offer D=10 at count=37 of a D=100 period that began after edge 300.
  task automatic test_cfg_mid_period();
    logic exp_tick;
    repeat (37) step();
    cfg_valid = 1'b1;
    cfg_div   = 16'd10;
    for (int e = 338; e <= 430; e++) begin
      step();
      cfg_valid = 1'b0;
      exp_tick = (ecnt == 400) || (ecnt > 400 && (ecnt - 400) % 10 == 0);
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("FAIL cfg_mid_tick edge=%0d got=%b exp=%b", ecnt, tick, exp_tick);
      end
      n_tests++;
      if (cfg_ready !== (ecnt >= 400) || busy !== (ecnt < 400)) begin
        n_fail++;
        $display("FAIL cfg_mid_ready_busy edge=%0d got=%b%b exp=%b%b", ecnt, cfg_ready, busy, (ecnt >= 400), (ecnt < 400));
      end
    end
  endtask

  // Offer D=5 on the wrap edge 440 of a D=10 stream: 450 still uses 10.
  task automatic test_cfg_on_wrap();
    logic exp_tick;
    repeat (9) step();
    cfg_valid = 1'b1;
    cfg_div   = 16'd5;
    for (int e = 440; e <= 460; e++) begin
      step();
      cfg_valid = 1'b0;
      exp_tick = (ecnt == 440) || (ecnt == 450) || (ecnt == 455) || (ecnt == 460);
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("FAIL cfg_wrap_tick edge=%0d got=%b exp=%b", ecnt, tick, exp_tick);
      end
      n_tests++;
      if (cfg_ready !== (ecnt >= 450)) begin
        n_fail++;
        $display("FAIL cfg_wrap_ready edge=%0d got=%b exp=%b", ecnt, cfg_ready, (ecnt >= 450));
      end
    end
  endtask

  // D=5, count=0 after edge 460: D=0 loads at 465, then D=1 is offered at 471.
  task automatic test_div_zero_one();
    cfg_valid = 1'b1;
    cfg_div   = 16'd0;
    step();
    cfg_valid = 1'b0;
    for (int e = 462; e <= 470; e++) begin
      step();
      n_tests++;
      if (tick !== (ecnt >= 465 || ecnt == 460)) begin
        n_fail++;
        $display("FAIL div0_tick edge=%0d got=%b exp=%b", ecnt, tick, (ecnt >= 465));
      end
    end
    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    for (int e = 471; e <= 476; e++) begin
      step();
      cfg_valid = 1'b0;
      n_tests++;
      if (tick !== 1'b1) begin
        n_fail++;
        $display("FAIL div1_tick edge=%0d got=%b exp=1", ecnt, tick);
      end
      n_tests++;
      if (cfg_ready !== (ecnt != 471)) begin
        n_fail++;
        $display("FAIL div1_ready edge=%0d got=%b exp=%b", ecnt, cfg_ready, (ecnt != 471));
      end
    end
  endtask

  // Back to D=10 (loaded at 478), then grant/revoke channel 2.
  task automatic test_channel_grant();
    logic [3:0] exp_ct;
    cfg_valid = 1'b1;
    cfg_div   = 16'd10;
    step();
    cfg_valid = 1'b0;
    repeat (4) step();
    en_req[2] = 1'b1;
    for (int e = 482; e <= 500; e++) begin
      step();
      exp_ct = (ecnt == 488 || ecnt == 498) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (en_ack !== ((ecnt >= 488) ? 4'b0100 : 4'b0000) || ch_tick !== exp_ct || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ch_grant edge=%0d got ack=%b ct=%b busy=%b exp ack=%b ct=%b busy=1",
                 ecnt, en_ack, ch_tick, busy, (ecnt >= 488) ? 4'b0100 : 4'b0000, exp_ct);
      end
    end
    en_req[2] = 1'b0;
    for (int e = 501; e <= 510; e++) begin
      step();
      n_tests++;
      if (en_ack !== ((ecnt < 508) ? 4'b0100 : 4'b0000) || ch_tick !== 4'b0000 ||
          busy !== (ecnt < 508) || tick !== (ecnt == 508)) begin
        n_fail++;
        $display("FAIL ch_revoke edge=%0d got ack=%b ct=%b busy=%b tick=%b exp ack=%b ct=0000 busy=%b tick=%b",
                 ecnt, en_ack, ch_tick, busy, tick, (ecnt < 508) ? 4'b0100 : 4'b0000, (ecnt < 508), (ecnt == 508));
      end
    end
  endtask

  // Two-cycle request on channel 0 that ends before the wrap at 518.
  task automatic test_arming_abort();
    en_req[0] = 1'b1;
    for (int e = 511; e <= 520; e++) begin
      step();
      if (ecnt == 512) en_req[0] = 1'b0;
      n_tests++;
      if (en_ack !== 4'b0000 || ch_tick !== 4'b0000 || busy !== (ecnt <= 512) || tick !== (ecnt == 518)) begin
        n_fail++;
        $display("FAIL arm_abort edge=%0d got ack=%b ct=%b busy=%b tick=%b exp ack=0000 ct=0000 busy=%b tick=%b",
                 ecnt, en_ack, ch_tick, busy, tick, (ecnt <= 512), (ecnt == 518));
      end
    end
  endtask

  // Channels 1 and 3 granted together at 528, config pending, then reset.
  task automatic test_back_to_back_reset();
    en_req = 4'b1010;
    for (int e = 521; e <= 528; e++) step();
    n_tests++;
    if (en_ack !== 4'b1010 || ch_tick !== 4'b1010 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_grant got ack=%b ct=%b tick=%b exp ack=1010 ct=1010 tick=1", en_ack, ch_tick, tick);
    end
    cfg_valid = 1'b1;
    cfg_div   = 16'd7;
    step();
    cfg_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_before_reset got busy=%b ready=%b exp busy=1 ready=0", busy, cfg_ready);
    end
    en_req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tick, ch_tick, en_ack, cfg_ready, busy} !== 11'b0_0000_0000_1_0) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=%b", {tick, ch_tick, en_ack, cfg_ready, busy}, 11'b0_0000_0000_1_0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ecnt = 0;
    for (int e = 1; e <= 110; e++) begin
      step();
      n_tests++;
      if (tick !== (ecnt == 100) || cfg_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset edge=%0d got tick=%b ready=%b busy=%b exp tick=%b ready=1 busy=0",
                 ecnt, tick, cfg_ready, busy, (ecnt == 100));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_cfg_mid_period();
    test_cfg_on_wrap();
    test_div_zero_one();
    test_channel_grant();
    test_arming_abort();
    test_back_to_back_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
